input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Upstream front-end for the lab4 bit-counting datapath and later labs.
- Takes raw board KEY and SW inputs and produces three things: metastability-safe switch values, debounced key levels, and one-cycle press/release pulses.
- On a debounced press of the start key, it captures a switch snapshot with a one-cycle valid strobe. The counter FSM consumes this as its start and load operand.

Parameters:
- NUM_KEYS, 4: number of KEY inputs conditioned.
- SW_WIDTH, 8: number of SW inputs synchronized and snapshotted.
- DEBOUNCE_CYCLES, 500000: stable cycles required before a key change is accepted (10 ms at 50 MHz); legal range is 1 or greater.
- START_KEY, 3: index of the key whose debounced press triggers the snapshot.

Ports:
- CLOCK_50  in  1  sole clock; all state is on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- KEY  in  NUM_KEYS  raw board keys, active-low (0 = pressed), asynchronous to CLOCK_50.
- SW  in  SW_WIDTH  raw switches, asynchronous.
- SW_Stable  out  SW_WIDTH  SW after 2-flop synchronization.
- key_level  out  NUM_KEYS  debounced key state, active-high (1 = held).
- key_press  out  NUM_KEYS  one-cycle pulse per key on accepted press.
- key_release  out  NUM_KEYS  one-cycle pulse per key on accepted release.
- sw_snapshot  out  SW_WIDTH  SW_Stable captured at the START_KEY press; holds until the next press.
- snapshot_valid  out  1  one-cycle strobe, coincident with sw_snapshot update.

Behaviour:
- Reset (async assert, sync-to-clock deassert not required here):
  - KEY sync flops = all 1 (released); SW sync flops = 0.
  - All debounce FSMs = UP, counters = 0.
  - key_level = 0, key_press = 0, key_release = 0, sw_snapshot = 0, snapshot_valid = 0.
- Synchronizer: two flops per bit for KEY and SW; SW_Stable is the second stage, giving 2 edges of latency.
- Per-key debounce FSM operates on the active-high synchronized key, p = ~key_sync2:
  - UP: if p=1, go to WAIT_DOWN with cnt=0; else stay.
  - WAIT_DOWN:
    - if p=0, go to UP, cnt=0 (glitch rejected, no pulse);
    - else if cnt == DEBOUNCE_CYCLES-1, go to DOWN;
    - else cnt++.
  - DOWN: if p=0, go to WAIT_UP with cnt=0; else stay.
  - WAIT_UP: mirror of WAIT_DOWN. If p=1, return to DOWN; at cnt == DEBOUNCE_CYCLES-1, go to UP.
- key_level = 1 in DOWN and WAIT_UP, registered.
- key_press[i] is high for exactly the one cycle after the WAIT_DOWN to DOWN edge. key_release[i] is the same for WAIT_UP to UP.
- Latency: a raw KEY low that is stable from edge 0 sets key_level and key_press after edge DEBOUNCE_CYCLES+2. Release is symmetric.
- A bounce shorter than DEBOUNCE_CYCLES stable cycles restarts qualification. Every accepted transition produces exactly one pulse.
- Counter width = $clog2(DEBOUNCE_CYCLES+1); it never wraps because it is cleared on every state change.
- Keys are fully independent. Simultaneous presses on several keys each pulse in the same cycle.
- Snapshot: on the edge where key_press[START_KEY] is 1:
  - sw_snapshot <= SW_Stable (the value present in that cycle);
  - snapshot_valid <= 1 for one cycle, so it trails key_press by one cycle.
  - SW changes while the key is held do not alter sw_snapshot.
- Reset asserted mid-qualification or while held: immediate return to the reset values above, with no pulse emitted. After deassert, a still-held key must re-qualify the full DEBOUNCE_CYCLES+2.
- DEBOUNCE_CYCLES=1: a single stable sampled cycle is accepted, giving latency 3.

Decomposition:
- Package input_cond_pkg holds:
  - the enum deb_state_t {UP, WAIT_DOWN, DOWN, WAIT_UP};
  - the default debounce constant for 50 MHz, and a simulation value of 4.
- Sub-module key_debounce: one channel containing the synchronizer, FSM, counter, level and pulses.
- input_conditioner instantiates NUM_KEYS copies via generate, plus the SW synchronizer and snapshot register.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset_n low mid-cycle, with KEY=4'hF and SW=8'hA5 applied -> all outputs 0 immediately (async). SW_Stable = 8'hA5 two edges after Reset_n rises.
2. KEY[3] held low from edge 0 -> key_level[3]=1 and key_press[3]=1 after edge 6. key_press[3]=0 after edge 7. No other key bits change.
3. KEY[0] low for 3 cycles, high for 1, then low steadily -> no pulse during the bounce. key_press[0] occurs 6 edges after the final low, exactly once.
4. SW=8'b1011_0010, then KEY[3] pressed -> snapshot_valid=1 one cycle after key_press[3], with sw_snapshot=8'hB2. Change SW to 8'hFF while held -> sw_snapshot stays 8'hB2.
5. KEY[3] released after stable hold -> key_release[3] pulses once after 6 edges, key_level[3]=0. A second press re-snapshots the current SW.
6. KEY[0] and KEY[3] pressed on the same edge, then Reset_n pulsed low at qualification cycle 3 -> no pulses emitted. After release of reset with keys still held, both key_press bits pulse together 6 edges later.

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared types and constants for the board input conditioner.
package input_cond_pkg;

  // Per-key debounce states, from a released key through a press and back.
  typedef enum logic [1:0] {
    UP        = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } deb_state_t;

  // 10 ms of stable input at 50 MHz.
  localparam int DEBOUNCE_CYCLES_50MHZ = 500000;
  // Short qualification window so simulations stay small.
  localparam int DEBOUNCE_CYCLES_SIM   = 4;

endpackage

// File: rtl/key_debounce.sv
// One key channel: two-flop synchronizer, debounce FSM with qualification
// counter, registered level and one-cycle press/release pulses.
//
// state     | meaning
// ----------+------------------------------------------------------------
// UP        | key released and accepted as released
// WAIT_DOWN | key seen pressed, counting stable cycles before accepting
// DOWN      | key pressed and accepted as pressed
// WAIT_UP   | key seen released, counting stable cycles before accepting
module key_debounce
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, press_q, release_q;
  logic          pressed;

  // The raw key is active-low; the FSM works on the active-high sample.
  assign pressed = ~sync_q[1];

  // Synchronizer resets to "released" so reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], key_raw_i};
  end

  // Next-state and counter logic; the counter is cleared on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      UP: begin
        if (pressed) begin
          state_d = WAIT_DOWN;
          cnt_d   = '0;
        end
      end
      WAIT_DOWN: begin
        if (!pressed) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (!pressed) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end
      end
      WAIT_UP: begin
        if (pressed) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; pulses mark accepted transitions only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= (state_d == DOWN) || (state_d == WAIT_UP);
      press_q   <= (state_q == WAIT_DOWN) && (state_d == DOWN);
      release_q <= (state_q == WAIT_UP) && (state_d == UP);
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/input_conditioner.sv
// Board front-end: synchronizes switches, debounces keys, and captures a
// switch snapshot when the start key is pressed.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int SW_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int START_KEY       = 3
) (
  input  logic                CLOCK_50,
  input  logic                Reset_n,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [SW_WIDTH-1:0] SW,
  output logic [SW_WIDTH-1:0] SW_Stable,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [SW_WIDTH-1:0] sw_snapshot,
  output logic                snapshot_valid
);

  logic [SW_WIDTH-1:0] sw_sync1_q, sw_sync2_q;
  logic [SW_WIDTH-1:0] snap_q;
  logic                snap_valid_q;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk_i     (CLOCK_50),
      .rst_ni    (Reset_n),
      .key_raw_i (KEY[g]),
      .level_o   (key_level[g]),
      .press_o   (key_press[g]),
      .release_o (key_release[g])
    );
  end

  // Two-flop switch synchronizer.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= SW;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  // Snapshot the synchronized switches on the start-key press pulse; the
  // strobe therefore trails the press pulse by one cycle.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      if (key_press[START_KEY]) snap_q <= sw_sync2_q;
      snap_valid_q <= key_press[START_KEY];
    end
  end

  assign SW_Stable      = sw_sync2_q;
  assign sw_snapshot    = snap_q;
  assign snapshot_valid = snap_valid_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with a short debounce window. Expected pulse
// events are queued when stimulus is driven; a monitor pops and compares
// them when the DUT pulses. Levels and snapshots are checked inline.
module tb_input_conditioner;
  import input_cond_pkg::*;

  localparam int DEB = DEBOUNCE_CYCLES_SIM;
  localparam int LAT = DEB + 3;  // cycles from driving KEY to seeing the pulse

  logic       CLOCK_50 = 1'b0;
  logic       Reset_n;
  logic [3:0] KEY;
  logic [7:0] SW;
  logic [7:0] SW_Stable;
  logic [3:0] key_level, key_press, key_release;
  logic [7:0] sw_snapshot;
  logic       snapshot_valid;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic       valid;
    logic [7:0] snap;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;

  input_conditioner #(
    .NUM_KEYS(4), .SW_WIDTH(8), .DEBOUNCE_CYCLES(DEB), .START_KEY(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .Reset_n(Reset_n), .KEY(KEY), .SW(SW),
    .SW_Stable(SW_Stable), .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .sw_snapshot(sw_snapshot),
    .snapshot_valid(snapshot_valid)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  // Scoreboard monitor: every pulse must match the next queued event.
  always @(posedge CLOCK_50) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missed_pulse: expected at cycle %0d press=%b release=%b valid=%b, no pulse observed by cycle %0d",
               exp_q[0].cyc, exp_q[0].press, exp_q[0].rel, exp_q[0].valid, cyc);
      void'(exp_q.pop_front());
    end
    if (|key_press || |key_release || snapshot_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cycle %0d press=%b release=%b valid=%b snap=%h, none expected",
                 cyc, key_press, key_release, snapshot_valid, sw_snapshot);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc !== cyc || key_press !== mon_e.press || key_release !== mon_e.rel ||
            snapshot_valid !== mon_e.valid || (mon_e.valid && sw_snapshot !== mon_e.snap)) begin
          n_fail++;
          $display("FAIL pulse_event: got cycle %0d press=%b release=%b valid=%b snap=%h, want cycle %0d press=%b release=%b valid=%b snap=%h",
                   cyc, key_press, key_release, snapshot_valid, sw_snapshot,
                   mon_e.cyc, mon_e.press, mon_e.rel, mon_e.valid, mon_e.snap);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                         input logic v, input logic [7:0] s);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.valid = v; e.snap = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
    tick();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; KEY = 4'hF; SW = 8'h5A;
    repeat (2) tick();
    Reset_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (SW_Stable !== 8'h5A) begin
      n_fail++; $display("FAIL sw_sync_before_reset: got %h want 5a", SW_Stable);
    end
    SW = 8'hA5;
    #8 Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({SW_Stable, key_level, key_press, key_release, sw_snapshot, snapshot_valid} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: sw_stable=%h level=%b press=%b rel=%b snap=%h valid=%b, want all 0",
               SW_Stable, key_level, key_press, key_release, sw_snapshot, snapshot_valid);
    end
    repeat (2) tick();
    Reset_n = 1'b1;
    tick();
    n_checks++;
    if (SW_Stable !== 8'h00) begin
      n_fail++; $display("FAIL sw_sync_edge1: got %h want 00", SW_Stable);
    end
    tick();
    n_checks++;
    if (SW_Stable !== 8'hA5) begin
      n_fail++; $display("FAIL sw_sync_edge2: got %h want a5", SW_Stable);
    end
  endtask

  task automatic test_single_press();
    int c;
    logic [3:0] want;
    c = cyc;
    KEY = 4'b0111;
    push_ev(c + LAT, 4'b1000, 4'b0000, 1'b0, 8'h00);
    push_ev(c + LAT + 1, 4'b0000, 4'b0000, 1'b1, 8'hA5);
    for (int i = 0; i < DEB + 6; i++) begin
      tick();
      want = (cyc >= c + LAT) ? 4'b1000 : 4'b0000;
      n_checks++;
      if (key_level !== want) begin
        n_fail++; $display("FAIL press_level: cycle %0d got %b want %b", cyc, key_level, want);
      end
    end
  endtask

  task automatic test_release();
    int c;
    logic [3:0] want;
    c = cyc;
    KEY = 4'hF;
    push_ev(c + LAT, 4'b0000, 4'b1000, 1'b0, 8'h00);
    for (int i = 0; i < DEB + 6; i++) begin
      tick();
      want = (cyc >= c + LAT) ? 4'b0000 : 4'b1000;
      n_checks++;
      if (key_level !== want) begin
        n_fail++; $display("FAIL release_level: cycle %0d got %b want %b", cyc, key_level, want);
      end
    end
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL release_drain: %0d events left, want 0", exp_q.size());
    end
  endtask

  task automatic test_bounce();
    int c;
    logic [3:0] want;
    KEY = 4'b1110;
    repeat (3) tick();
    KEY = 4'hF;
    tick();
    c = cyc;
    KEY = 4'b1110;
    push_ev(c + LAT, 4'b0001, 4'b0000, 1'b0, 8'h00);
    for (int i = 0; i < DEB + 6; i++) begin
      tick();
      want = (cyc >= c + LAT) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (key_level !== want) begin
        n_fail++; $display("FAIL bounce_level: cycle %0d got %b want %b", cyc, key_level, want);
      end
    end
    c = cyc;
    KEY = 4'hF;
    push_ev(c + LAT, 4'b0000, 4'b0001, 1'b0, 8'h00);
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0 || key_level !== 4'b0000) begin
      n_fail++; $display("FAIL bounce_drain: events left %0d level %b, want 0 and 0000", exp_q.size(), key_level);
    end
  endtask

  task automatic test_snapshot();
    int c;
    SW = 8'b1011_0010;
    repeat (3) tick();
    c = cyc;
    KEY = 4'b0111;
    push_ev(c + LAT, 4'b1000, 4'b0000, 1'b0, 8'h00);
    push_ev(c + LAT + 1, 4'b0000, 4'b0000, 1'b1, 8'hB2);
    repeat (DEB + 5) tick();
    n_checks++;
    if (sw_snapshot !== 8'hB2 || key_level !== 4'b1000) begin
      n_fail++; $display("FAIL snapshot_capture: snap %h level %b, want b2 1000", sw_snapshot, key_level);
    end
    SW = 8'hFF;
    repeat (5) tick();
    n_checks++;
    if (sw_snapshot !== 8'hB2 || SW_Stable !== 8'hFF) begin
      n_fail++; $display("FAIL snapshot_hold: snap %h sw_stable %h, want b2 ff", sw_snapshot, SW_Stable);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    c = cyc;
    KEY = 4'hF;
    push_ev(c + LAT, 4'b0000, 4'b1000, 1'b0, 8'h00);
    repeat (DEB + 5) tick();
    n_checks++;
    if (key_level !== 4'b0000 || sw_snapshot !== 8'hB2) begin
      n_fail++; $display("FAIL b2b_release: level %b snap %h, want 0000 b2", key_level, sw_snapshot);
    end
    c = cyc;
    KEY = 4'b0111;
    push_ev(c + LAT, 4'b1000, 4'b0000, 1'b0, 8'h00);
    push_ev(c + LAT + 1, 4'b0000, 4'b0000, 1'b1, 8'hFF);
    repeat (DEB + 5) tick();
    n_checks++;
    if (sw_snapshot !== 8'hFF) begin
      n_fail++; $display("FAIL b2b_resnap: snap %h, want ff", sw_snapshot);
    end
    c = cyc;
    KEY = 4'hF;
    push_ev(c + LAT, 4'b0000, 4'b1000, 1'b0, 8'h00);
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: %0d events left, want 0", exp_q.size());
    end
  endtask

  task automatic test_simul_reset();
    int r;
    logic [3:0] want;
    KEY = 4'b0110;
    repeat (4) tick();
    #8 Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({SW_Stable, key_level, key_press, key_release, sw_snapshot, snapshot_valid} !== '0) begin
      n_fail++;
      $display("FAIL midqual_reset: sw_stable=%h level=%b press=%b rel=%b snap=%h valid=%b, want all 0",
               SW_Stable, key_level, key_press, key_release, sw_snapshot, snapshot_valid);
    end
    repeat (2) tick();
    Reset_n = 1'b1;
    r = cyc;
    push_ev(r + LAT, 4'b1001, 4'b0000, 1'b0, 8'h00);
    push_ev(r + LAT + 1, 4'b0000, 4'b0000, 1'b1, 8'hFF);
    for (int i = 0; i < DEB + 6; i++) begin
      tick();
      want = (cyc >= r + LAT) ? 4'b1001 : 4'b0000;
      n_checks++;
      if (key_level !== want) begin
        n_fail++; $display("FAIL requal_level: cycle %0d got %b want %b", cyc, key_level, want);
      end
    end
    r = cyc;
    KEY = 4'hF;
    push_ev(r + LAT, 4'b0000, 4'b1001, 1'b0, 8'h00);
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0 || key_level !== 4'b0000) begin
      n_fail++; $display("FAIL requal_drain: events left %0d level %b, want 0 and 0000", exp_q.size(), key_level);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_snapshot();
    test_back_to_back();
    test_simul_reset();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
